mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 3, SRAM access duration in cycles (legal 1..15).
REQ-002 The module SHALL have parameter SRAM_AW, default 16, SRAM word-address width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  fetch request; held high until if_ready.
REQ-006 if_addr  input  32  fetch byte address (the PC).
REQ-007 if_flush  input  1  branch taken; the outstanding fetch is stale.
REQ-008 if_rdata  output  32  fetched instruction, valid when if_ready=1.
REQ-009 if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 if_freeze  output  1  freeze to the fetch stage.
REQ-011 mem_rd_en, mem_wr_en  input  1 each  data load/store request; held until mem_ready.
REQ-012 mem_addr, mem_wdata  input  32 each  data byte address and store data.
REQ-013 mem_rdata  output  32  load data, valid when mem_ready=1.
REQ-014 mem_ready  output  1  one-cycle data completion pulse.
REQ-015 mem_freeze  output  1  freeze to the memory stage and the upstream pipeline.
REQ-016 sram_en  output  1  SRAM access strobe.
REQ-017 sram_we  output  1  SRAM write strobe.
REQ-018 sram_addr  output  SRAM_AW  word address, equal to addr[SRAM_AW+1:2].
REQ-019 sram_wdata  output  32  write data.
REQ-020 sram_rdata  input  32  read data, valid in the last access cycle.

Function
REQ-021 The FSM SHALL have five states: IDLE, IF_ACC, MEM_ACC, IF_DONE and MEM_DONE.
REQ-022 In IDLE with a data request (rd or wr) pending, the FSM SHALL latch the address and data, load the counter with WAIT_CYCLES-1, and go to MEM_ACC; data requests have priority over fetch.
REQ-023 In IDLE with only if_req pending and if_flush low, the FSM SHALL latch if_addr, load the counter, and go to IF_ACC.
REQ-024 In IDLE with if_req and if_flush both high, the FSM SHALL not grant the fetch.
REQ-025 In both ACC states, sram_en SHALL be 1 and sram_addr/sram_wdata SHALL come from the latched registers, stable for the whole access.
REQ-026 In MEM_ACC, sram_we SHALL be 1 only for a write; sram_we SHALL be 0 in every other state.
REQ-027 In ACC, the counter SHALL decrement each cycle; at 0, the FSM SHALL capture sram_rdata and go to the matching DONE state.
REQ-028 A DONE state SHALL last exactly one cycle, assert the corresponding ready, and then return to IDLE.
REQ-029 No grant SHALL be issued in a DONE state.
REQ-030 Latency SHALL be fixed: request seen in IDLE at cycle 0, ready in cycle WAIT_CYCLES+1.
REQ-031 Throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-032 if_freeze SHALL equal if_req & ~if_ready; mem_freeze SHALL equal (mem_rd_en|mem_wr_en) & ~mem_ready.
REQ-033 An if_flush during IF_ACC or IF_DONE SHALL set a drop flag.
REQ-034 A dropped access SHALL still complete on the SRAM, but if_ready SHALL be suppressed in IF_DONE; the flag SHALL clear on return to IDLE.
REQ-035 A data request that arrives during IF_ACC SHALL wait and be granted at the next IDLE.
REQ-036 If mem_rd_en and mem_wr_en are both high, the access SHALL be treated as a write.
REQ-037 if_rdata and mem_rdata SHALL hold their last captured value between accesses.

Reset
REQ-038 On rst, asynchronously: state IDLE, counter 0, drop flag 0, all latches 0, if_rdata and mem_rdata 0, sram_en/sram_we/if_ready/mem_ready 0.
REQ-039 A reset mid-access SHALL abort the access with no ready pulse; the first grant SHALL occur in the first cycle after rst falls.

Structure
REQ-040 A shared package SHALL hold the state enum, the WAIT_CYCLES default and the SRAM_AW default.
REQ-041 One sub-module, access_timer (4-bit loadable down-counter with a zero flag), SHALL be instantiated.

Verification
REQ-042 Fetch only, WAIT_CYCLES=3, if_addr=0x8, sram word 2=0xE3A00014 -> sram_addr=2 for 3 cycles, if_ready in cycle 4, if_rdata=0xE3A00014, if_freeze high in cycles 0-3.
REQ-043 if_req and mem_rd_en high in the same cycle (mem_addr=0x400) -> the data access is served first; mem_ready at cycle 4; the fetch is granted at cycle 5; if_ready at cycle 9.
REQ-044 Store mem_addr=0x400, wdata=0x2000, then load 0x400 -> sram_we=1 only during the store ACC; load mem_rdata=0x2000.
REQ-045 Assert if_flush in the second IF_ACC cycle -> the access completes, no if_ready pulse, and the FSM is IDLE at cycle 5.
REQ-046 Assert rst during MEM_ACC -> sram_en=0 immediately, no mem_ready; a re-issued request completes normally with latency 4.
REQ-047 WAIT_CYCLES=1, back-to-back fetches 0x0, 0x4 -> if_ready at cycles 2 and 5.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared types and defaults for the fetch/data SRAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_WAIT_CYCLES_DEFAULT = 3;
    localparam int c_SRAM_AW_DEFAULT     = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_ACC   = 3'd1,
        ST_MEM_ACC  = 3'd2,
        ST_IF_DONE  = 3'd3,
        ST_MEM_DONE = 3'd4
    } arb_state_t;

    // The timer counts the remaining access cycles down to zero.
    function automatic logic [3:0] timer_preset(input int wait_cycles);
        return 4'(wait_cycles - 1);
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Brief    : Fetch, data and SRAM handshake bundle around the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int SRAM_AW = c_SRAM_AW_DEFAULT
) ();

    logic               if_req;
    logic [31:0]        if_addr;
    logic               if_flush;
    logic [31:0]        if_rdata;
    logic               if_ready;
    logic               if_freeze;

    logic               mem_rd_en;
    logic               mem_wr_en;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic               mem_freeze;

    logic               sram_en;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, if_freeze, mem_rdata, mem_ready, mem_freeze,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    // Pipeline and SRAM side
    modport master (
        output if_req, if_addr, if_flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, if_freeze, mem_rdata, mem_ready, mem_freeze,
               sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_access_timer.sv
`default_nettype none
// ============================================================================
//  Module   : access_timer
//  Brief    : 4-bit loadable down-counter with a zero flag; stops at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module access_timer (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [3:0] i_load_val,
    input  wire logic       i_dec,
    output logic            o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule : access_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one single-port SRAM between fetch and data stages,
//             data first, fixed WAIT_CYCLES access time.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = c_WAIT_CYCLES_DEFAULT,
    parameter int SRAM_AW     = c_SRAM_AW_DEFAULT
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] c_TIMER_LOAD = timer_preset(WAIT_CYCLES);

    arb_state_t         r_state;
    logic [SRAM_AW-1:0] r_word_addr;
    logic [31:0]        r_wdata;
    logic               r_sram_en;
    logic               r_sram_we;
    logic               r_drop;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_mem_rdata;
    logic               r_if_ready;
    logic               r_mem_ready;

    logic w_mem_req;
    logic w_if_grantable;
    logic w_grant;
    logic w_in_acc;
    logic w_timer_zero;
    logic w_unused_addr_bits;

    assign w_mem_req      = bus.mem_rd_en | bus.mem_wr_en;
    assign w_if_grantable = bus.if_req & ~bus.if_flush;
    assign w_grant        = (r_state == ST_IDLE) & (w_mem_req | w_if_grantable);
    assign w_in_acc       = (r_state == ST_IF_ACC) | (r_state == ST_MEM_ACC);

    // Byte-offset and high address bits never reach the word-addressed SRAM.
    assign w_unused_addr_bits = ^{bus.if_addr[31:SRAM_AW+2],  bus.if_addr[1:0],
                                  bus.mem_addr[31:SRAM_AW+2], bus.mem_addr[1:0]};

    access_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grant),
        .i_load_val (c_TIMER_LOAD),
        .i_dec      (w_in_acc),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_sram_en   <= 1'b0;
            r_sram_we   <= 1'b0;
            r_drop      <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_mem_req) begin
                        r_word_addr <= bus.mem_addr[SRAM_AW+1:2];
                        r_wdata     <= bus.mem_wdata;
                        r_sram_en   <= 1'b1;
                        r_sram_we   <= bus.mem_wr_en;
                        r_state     <= ST_MEM_ACC;
                    end else if (w_if_grantable) begin
                        r_word_addr <= bus.if_addr[SRAM_AW+1:2];
                        r_sram_en   <= 1'b1;
                        r_sram_we   <= 1'b0;
                        r_state     <= ST_IF_ACC;
                    end
                end
                ST_IF_ACC: begin
                    if (bus.if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (w_timer_zero) begin
                        // A flush in the final access cycle still suppresses the pulse.
                        r_if_rdata <= bus.sram_rdata;
                        r_sram_en  <= 1'b0;
                        r_if_ready <= ~(r_drop | bus.if_flush);
                        r_state    <= ST_IF_DONE;
                    end
                end
                ST_MEM_ACC: begin
                    if (w_timer_zero) begin
                        if (!r_sram_we) begin
                            r_mem_rdata <= bus.sram_rdata;
                        end
                        r_sram_en   <= 1'b0;
                        r_sram_we   <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_MEM_DONE;
                    end
                end
                ST_IF_DONE: begin
                    r_drop  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_MEM_DONE: begin
                    r_drop  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sram_en    = r_sram_en;
    assign bus.sram_we    = r_sram_we;
    assign bus.sram_addr  = r_word_addr;
    assign bus.sram_wdata = r_wdata;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_ready   = r_if_ready;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.mem_ready  = r_mem_ready;
    assign bus.if_freeze  = bus.if_req & ~r_if_ready;
    assign bus.mem_freeze = w_mem_req & ~r_mem_ready;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter (WAIT_CYCLES 3 and 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W  = 3;
    localparam int W1 = 1;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.SRAM_AW(AW)) bus  ();
    mem_arbiter_if #(.SRAM_AW(AW)) bus1 ();

    mem_arbiter #(.WAIT_CYCLES(W),  .SRAM_AW(AW)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_arbiter #(.WAIT_CYCLES(W1), .SRAM_AW(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // SRAM model: combinational read, write on the clock edge; preload port for the bench.
    logic [31:0]   sram [0:65535];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we)
            sram[pre_addr] <= pre_data;
        else if (bus.sram_en && bus.sram_we)
            sram[bus.sram_addr] <= bus.sram_wdata;
    end
    assign bus.sram_rdata  = sram[bus.sram_addr];
    assign bus1.sram_rdata = sram[bus1.sram_addr];

    logic [31:0] model_mem [int];
    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
        bus.mem_rd_en = 1'b0;  bus.mem_wr_en = 1'b0;  bus.mem_addr = '0;  bus.mem_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.if_flush = 1'b0;
        bus1.mem_rd_en = 1'b0; bus1.mem_wr_en = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    endtask

    task automatic poke(input int word, input logic [31:0] data);
        pre_addr = AW'(word);
        pre_data = data;
        pre_we   = 1'b1;
        model_mem[word] = data;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        idle_inputs();
        pre_we = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus1.sram_en, bus1.if_ready};
        checks++;
        if (got !== 6'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000000", got);
        end
        checks++;
        if ({bus.if_rdata, bus.mem_rdata} !== 64'h0) begin
            failures++; $display("FAIL reset_rdata got=%h_%h exp=0", bus.if_rdata, bus.mem_rdata);
        end
        checks++;
        if ({bus.sram_addr, bus.sram_wdata} !== '0) begin
            failures++; $display("FAIL reset_latches got=%h_%h exp=0", bus.sram_addr, bus.sram_wdata);
        end
        rst = 1'b0;
    endtask

    // Single fetch of PC 0x8: ready exactly WAIT_CYCLES+1 cycles after the request.
    task automatic test_fetch();
        logic [5:0] got, exp;
        poke(2, 32'hE3A0_0014);
        for (int i = 0; i <= 6; i++) begin
            bus.if_req  = (i <= W + 1);
            bus.if_addr = 32'h8;
            #1;
            exp = {(i >= 1 && i <= W), 1'b0, (i == W + 1), 1'b0, (i < W + 1), 1'b0};
            got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus.if_freeze, bus.mem_freeze};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL fetch_ctl cyc=%0d got=%b exp=%b", i, got, exp);
            end
            if (i >= 1 && i <= W) begin
                checks++;
                if (bus.sram_addr !== 16'd2) begin
                    failures++; $display("FAIL fetch_addr cyc=%0d got=%h exp=0002", i, bus.sram_addr);
                end
            end
            if (i == W + 1) begin
                checks++;
                if (bus.if_rdata !== 32'hE3A0_0014) begin
                    failures++; $display("FAIL fetch_data got=%h exp=e3a00014", bus.if_rdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    // Simultaneous fetch and load: the load wins, the fetch follows.
    task automatic test_priority();
        logic [5:0] got, exp;
        logic [31:0] dmem, dif;
        logic if_pend, mem_pend;
        dmem = $urandom();
        dif  = $urandom();
        poke(32'h100, dmem);
        poke(32'h230, dif);
        if_pend = 1'b1; mem_pend = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            bus.if_req = if_pend;   bus.if_addr  = 32'h8C0;
            bus.mem_rd_en = mem_pend; bus.mem_addr = 32'h400;
            #1;
            exp = {((i >= 1 && i <= 3) || (i >= 6 && i <= 8)), 1'b0, (i == 9), (i == 4),
                   (if_pend && i != 9), (mem_pend && i != 4)};
            got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus.if_freeze, bus.mem_freeze};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL prio_ctl cyc=%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 4) begin
                checks++;
                if (bus.mem_rdata !== dmem) begin
                    failures++; $display("FAIL prio_mem_data got=%h exp=%h", bus.mem_rdata, dmem);
                end
                mem_pend = 1'b0;
            end
            if (i == 7) begin
                checks++;
                if (bus.sram_addr !== 16'h230) begin
                    failures++; $display("FAIL prio_if_addr got=%h exp=0230", bus.sram_addr);
                end
            end
            if (i == 9) begin
                checks++;
                if (bus.if_rdata !== dif) begin
                    failures++; $display("FAIL prio_if_data got=%h exp=%h", bus.if_rdata, dif);
                end
                if_pend = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_store_load();
        logic [5:0] got, exp;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i <= 5; i++) begin
                bus.mem_addr  = 32'h400;
                bus.mem_wdata = 32'h2000;
                bus.mem_wr_en = (pass == 0) && (i <= 4);
                bus.mem_rd_en = (pass == 1) && (i <= 4);
                #1;
                exp = {(i >= 1 && i <= 3), (pass == 0 && i >= 1 && i <= 3), 1'b0, (i == 4), 1'b0, (i < 4)};
                got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus.if_freeze, bus.mem_freeze};
                checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL stld_ctl pass=%0d cyc=%0d got=%b exp=%b", pass, i, got, exp);
                end
                if (pass == 1 && i == 4) begin
                    checks++;
                    if (bus.mem_rdata !== 32'h2000) begin
                        failures++; $display("FAIL load_data got=%h exp=00002000", bus.mem_rdata);
                    end
                end
                tick();
            end
        end
        model_mem[32'h100] = 32'h2000;
        idle_inputs();
    endtask

    // Flush in the second access cycle; a fresh fetch at cycle 5 proves the FSM is idle.
    task automatic test_flush();
        logic [5:0] got, exp;
        logic [31:0] d2;
        d2 = $urandom();
        poke(32'h40, $urandom());
        poke(32'h41, d2);
        for (int i = 0; i <= 10; i++) begin
            bus.if_req   = (i <= 2) || (i >= 5 && i <= 9);
            bus.if_addr  = (i < 5) ? 32'h100 : 32'h104;
            bus.if_flush = (i == 2);
            #1;
            exp = {((i >= 1 && i <= 3) || (i >= 6 && i <= 8)), 1'b0, (i == 9), 1'b0,
                   (bus.if_req && i != 9), 1'b0};
            got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus.if_freeze, bus.mem_freeze};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL flush_ctl cyc=%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 9) begin
                checks++;
                if (bus.if_rdata !== d2) begin
                    failures++; $display("FAIL flush_refetch_data got=%h exp=%h", bus.if_rdata, d2);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [5:0] got, exp;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = 32'h400;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.sram_en, bus.mem_ready} !== 2'b00) begin
            failures++; $display("FAIL rstmid_abort got=%b exp=00", {bus.sram_en, bus.mem_ready});
        end
        tick();
        checks++;
        if ({bus.mem_ready, bus.mem_rdata} !== 33'h0) begin
            failures++; $display("FAIL rstmid_clear got=%b_%h exp=0", bus.mem_ready, bus.mem_rdata);
        end
        rst = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            bus.mem_rd_en = (i <= 4);
            #1;
            exp = {(i >= 1 && i <= 3), 1'b0, 1'b0, (i == 4), 1'b0, (i < 4)};
            got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus.if_freeze, bus.mem_freeze};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL rstmid_reissue cyc=%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 4) begin
                checks++;
                if (bus.mem_rdata !== 32'h2000) begin
                    failures++; $display("FAIL rstmid_data got=%h exp=00002000", bus.mem_rdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    // WAIT_CYCLES=1 instance: back-to-back fetches of 0x0 and 0x4.
    task automatic test_wait1();
        logic [1:0] got, exp;
        logic [31:0] d0, d1;
        d0 = $urandom(); d1 = $urandom();
        poke(0, d0);
        poke(1, d1);
        for (int i = 0; i <= 6; i++) begin
            bus1.if_req  = (i <= 5);
            bus1.if_addr = (i <= 2) ? 32'h0 : 32'h4;
            #1;
            exp = {(i == 1 || i == 4), (i == 2 || i == 5)};
            got = {bus1.sram_en, bus1.if_ready};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL w1_ctl cyc=%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 2 || i == 5) begin
                checks++;
                if (bus1.if_rdata !== ((i == 2) ? d0 : d1)) begin
                    failures++; $display("FAIL w1_data cyc=%0d got=%h exp=%h", i, bus1.if_rdata, (i == 2) ? d0 : d1);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    // Random mix of fetch / load / store / combined requests against a timing and memory model.
    task automatic test_random();
        logic [5:0]  got, exp;
        logic [31:0] wd, exp_if, exp_md, last_if, last_md;
        logic        has_if, has_mem, is_wr, if_pend, mem_pend, last_if_ok, last_md_ok, en_exp;
        int          kind, fa, ma, if_t, mem_t, last_t;
        for (int w = 0; w < 32; w++) poke(32'h200 + w, $urandom());
        last_if_ok = 1'b0; last_md_ok = 1'b0; last_if = '0; last_md = '0;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            fa   = 32'h200 + int'($urandom_range(0, 31));
            ma   = 32'h200 + int'($urandom_range(0, 31));
            wd   = $urandom();
            has_if  = (kind == 0) || (kind >= 3);
            has_mem = (kind != 0);
            is_wr   = (kind == 2) || (kind == 4);
            repeat ($urandom_range(0, 2)) begin
                #1;
                checks++;
                if (bus.sram_en !== 1'b0) begin
                    failures++; $display("FAIL rnd_idle_en txn=%0d got=%b exp=0", n, bus.sram_en);
                end
                tick();
            end
            mem_t  = W + 1;
            if_t   = has_mem ? 2 * W + 3 : W + 1;
            last_t = has_if ? if_t : mem_t;
            if (is_wr) model_mem[ma] = wd;
            exp_md = model_mem[ma];
            exp_if = model_mem[fa];
            if_pend = has_if; mem_pend = has_mem;
            for (int i = 0; i <= last_t; i++) begin
                bus.if_req    = if_pend;
                bus.if_addr   = fa << 2;
                bus.mem_addr  = ma << 2;
                bus.mem_wdata = wd;
                bus.mem_wr_en = mem_pend && is_wr;
                bus.mem_rd_en = mem_pend && (!is_wr || ($urandom_range(0, 1) == 1));
                #1;
                en_exp = (has_mem && i >= 1 && i <= W) || (has_if && i >= if_t - W && i <= if_t - 1);
                exp = {en_exp, (is_wr && i >= 1 && i <= W), (has_if && i == if_t), (has_mem && i == mem_t),
                       (if_pend && !(has_if && i == if_t)), (mem_pend && !(has_mem && i == mem_t))};
                got = {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready, bus.if_freeze, bus.mem_freeze};
                checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL rnd_ctl txn=%0d kind=%0d cyc=%0d got=%b exp=%b", n, kind, i, got, exp);
                end
                if (has_if && i == if_t) begin
                    checks++;
                    if (bus.if_rdata !== exp_if) begin
                        failures++; $display("FAIL rnd_if_data txn=%0d got=%h exp=%h", n, bus.if_rdata, exp_if);
                    end
                    if_pend = 1'b0;
                end
                if (has_mem && i == mem_t) begin
                    if (!is_wr) begin
                        checks++;
                        if (bus.mem_rdata !== exp_md) begin
                            failures++; $display("FAIL rnd_mem_data txn=%0d got=%h exp=%h", n, bus.mem_rdata, exp_md);
                        end
                    end
                    mem_pend = 1'b0;
                end
                tick();
            end
            idle_inputs();
            if (!has_if && last_if_ok) begin
                checks++;
                if (bus.if_rdata !== last_if) begin
                    failures++; $display("FAIL rnd_if_hold txn=%0d got=%h exp=%h", n, bus.if_rdata, last_if);
                end
            end
            if (!has_mem && last_md_ok) begin
                checks++;
                if (bus.mem_rdata !== last_md) begin
                    failures++; $display("FAIL rnd_mem_hold txn=%0d got=%h exp=%h", n, bus.mem_rdata, last_md);
                end
            end
            if (has_if) begin last_if = exp_if; last_if_ok = 1'b1; end
            if (has_mem) begin last_md = exp_md; last_md_ok = !is_wr; end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store_load();
        test_flush();
        test_reset_mid();
        test_wait1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
